// File: rtl/ttl_video_timing_sync.sv
// ttl_video_timing_sync
// Horizontal/vertical video timing generator modelled on two cascaded
// 9-bit reloadable counter chains. Set/reset flip-flops decode the counts
// into blank and sync. Counting advances only on the rising edge of Cen,
// which is detected against a registered copy of Cen.
//
// Flag semantics: a flag sets when the freshly loaded count equals its ON
// value and clears when it equals its OFF value; ON has priority when both
// match. Horizontal flags are re-evaluated on every counted edge. Vertical
// flags are re-evaluated only on counted edges that wrap the H counter.
// This keeps every flag aligned with the count it was decoded from.
module ttl_video_timing_sync #(
  parameter logic [8:0] H_START    = 9'd128,
  parameter logic [8:0] HBLANK_ON  = 9'd384,
  parameter logic [8:0] HBLANK_OFF = 9'd128,
  parameter logic [8:0] HSYNC_ON   = 9'd416,
  parameter logic [8:0] HSYNC_OFF  = 9'd448,
  parameter logic [8:0] V_START    = 9'd248,
  parameter logic [8:0] VBLANK_ON  = 9'd496,
  parameter logic [8:0] VBLANK_OFF = 9'd272,
  parameter logic [8:0] VSYNC_ON   = 9'd504,
  parameter logic [8:0] VSYNC_OFF  = 9'd508
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Cen,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       PIX_CE,
  output logic       LINE_END,
  output logic       FRAME_START,
  output logic       FIELD
);

  localparam logic [8:0] CNT_MAX = 9'd511;

  logic       last_cen_q,    last_cen_d;
  logic [8:0] hcnt_q,        hcnt_d;
  logic [8:0] vcnt_q,        vcnt_d;
  logic       hblank_q,      hblank_d;
  logic       vblank_q,      vblank_d;
  logic       hsync_q,       hsync_d;
  logic       vsync_q,       vsync_d;
  logic       pix_ce_q,      pix_ce_d;
  logic       line_end_q,    line_end_d;
  logic       frame_start_q, frame_start_d;
  logic       field_q,       field_d;

  logic       cen_rise;
  logic       h_wrap;
  logic       v_wrap;

  // Set/reset flip-flop decode: set has priority over clear, otherwise hold.
  function automatic logic sr_next(input logic cur, input logic [8:0] cnt,
                                   input logic [8:0] on_v, input logic [8:0] off_v);
    logic nxt;
    nxt = cur;
    if (cnt == on_v) begin
      nxt = 1'b1;
    end else if (cnt == off_v) begin
      nxt = 1'b0;
    end
    return nxt;
  endfunction

  // Edge detect, counter chains, flag decode and pulse generation.
  always_comb begin
    last_cen_d    = Cen;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    field_d       = field_q;

    cen_rise      = Cen & ~last_cen_q;
    h_wrap        = cen_rise && (hcnt_q == CNT_MAX);
    v_wrap        = h_wrap && (vcnt_q == CNT_MAX);

    pix_ce_d      = cen_rise;
    line_end_d    = h_wrap;
    frame_start_d = v_wrap;

    if (cen_rise) begin
      hcnt_d   = h_wrap ? H_START : hcnt_q + 9'd1;
      hblank_d = sr_next(hblank_q, hcnt_d, HBLANK_ON, HBLANK_OFF);
      hsync_d  = sr_next(hsync_q,  hcnt_d, HSYNC_ON,  HSYNC_OFF);
    end

    if (h_wrap) begin
      vcnt_d   = v_wrap ? V_START : vcnt_q + 9'd1;
      field_d  = field_q ^ v_wrap;
      vblank_d = sr_next(vblank_q, vcnt_d, VBLANK_ON, VBLANK_OFF);
      vsync_d  = sr_next(vsync_q,  vcnt_d, VSYNC_ON,  VSYNC_OFF);
    end
  end

  // State registers; reset forces last_cen high so a Cen held high through
  // reset does not count an edge on release.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_cen_q    <= 1'b1;
      hcnt_q        <= H_START;
      vcnt_q        <= V_START;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      pix_ce_q      <= 1'b0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
      field_q       <= 1'b0;
    end else begin
      last_cen_q    <= last_cen_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pix_ce_q      <= pix_ce_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
      field_q       <= field_d;
    end
  end

  assign HCNT        = hcnt_q;
  assign VCNT        = vcnt_q;
  assign HBLANK      = hblank_q;
  assign VBLANK      = vblank_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign PIX_CE      = pix_ce_q;
  assign LINE_END    = line_end_q;
  assign FRAME_START = frame_start_q;
  assign FIELD       = field_q;

endmodule
